// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase codes, lamp constants and phase-order helper for the traffic blocks
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } phase_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // RED -> GREEN -> YELLOW -> RED; anything unexpected recovers to RED
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            RED:     return GREEN;
            GREEN:   return YELLOW;
            default: return RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_timer_prescaler.sv
// rtl/traffic_phase_timer_prescaler.sv - tick_prescaler: divides clk by CLK_DIV into a registered one-cycle tick
module tick_prescaler #(
    parameter int CLK_DIV = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // count 0..CLK_DIV-1 while enabled; tick follows the terminal count by one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (enable) begin
            if (r_cnt == LAST) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/traffic_phase_timer.sv
// rtl/traffic_phase_timer.sv - phase dwell timer with pedestrian shortening/extension; TRAFFIC_FLASH_EN adds flash mode
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int CLK_DIV       = 1000,
    parameter int CNT_W         = 8,
    parameter int RED_TICKS     = 30,
    parameter int GREEN_TICKS   = 25,
    parameter int YELLOW_TICKS  = 5,
    parameter int PED_EXT_TICKS = 10,
    parameter int PED_GREEN_MAX = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             ped_req,
`ifdef TRAFFIC_FLASH_EN
    input  logic             flash_mode,
    output logic             flash_lamp,
`endif
    output logic             ped_ack,
    output logic [1:0]       phase,
    output logic             advance,
    output logic             tick,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [1:0] S_RED    = RED;
    localparam logic [1:0] S_GREEN  = GREEN;
    localparam logic [1:0] S_YELLOW = YELLOW;
    localparam logic [1:0] S_BAD    = 2'd3;

    localparam logic [CNT_W-1:0] RED_LOAD    = CNT_W'(RED_TICKS - 1);
    localparam logic [CNT_W-1:0] RED_EXT     = CNT_W'(RED_TICKS + PED_EXT_TICKS - 1);
    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] GREEN_CLAMP = CNT_W'(PED_GREEN_MAX - 1);

    logic             w_tick;
    logic             w_step;
    logic [1:0]       r_phase, w_phase_n;
    logic [CNT_W-1:0] r_rem, w_rem_n;
    logic             r_adv, w_adv_n;
    logic             r_ack, w_ack_n;
    logic             r_pend, w_pend_n;
    logic             w_enter_red;
    logic             w_grant;
`ifdef TRAFFIC_FLASH_EN
    logic             r_flash_d;
    logic             r_lamp, w_lamp_n;
`endif

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .tick    (w_tick)
    );

    // a tick only counts while running, so a hold never consumes dwell time
    assign w_step = w_tick & enable;

    // next phase, dwell count, strobes and pedestrian bookkeeping
    always_comb begin
        w_phase_n   = r_phase;
        w_rem_n     = r_rem;
        w_adv_n     = 1'b0;
        w_ack_n     = 1'b0;
        w_enter_red = 1'b0;
        w_grant     = 1'b0;
`ifdef TRAFFIC_FLASH_EN
        w_lamp_n    = r_lamp;
        if (flash_mode) begin
            w_phase_n = S_YELLOW;
            if (w_step) begin
                w_lamp_n = ~r_lamp;
            end
        end else if (r_flash_d) begin
            w_lamp_n    = 1'b0;
            w_phase_n   = S_RED;
            w_adv_n     = 1'b1;
            w_enter_red = 1'b1;
        end else
`endif
        if (r_phase == S_BAD) begin
            w_phase_n = S_RED;
            w_rem_n   = RED_LOAD;
            w_adv_n   = 1'b1;
        end else if (w_step) begin
            if (r_rem != '0) begin
                w_rem_n = r_rem - 1'b1;
            end else begin
                w_phase_n = next_phase(phase_t'(r_phase));
                w_adv_n   = 1'b1;
                case (w_phase_n)
                    S_GREEN:  w_rem_n = GREEN_LOAD;
                    S_YELLOW: w_rem_n = YELLOW_LOAD;
                    default:  w_enter_red = 1'b1;
                endcase
            end
        end
        // a pending request buys the extended RED exactly once, on entry
        if (w_enter_red) begin
            if (r_pend) begin
                w_rem_n = RED_EXT;
                w_ack_n = 1'b1;
                w_grant = 1'b1;
            end else begin
                w_rem_n = RED_LOAD;
            end
        end
        // pending request cuts GREEN short, including the edge that enters it
        if (r_pend && (w_phase_n == S_GREEN) && (w_rem_n > GREEN_CLAMP)) begin
            w_rem_n = GREEN_CLAMP;
        end
        // a request seen on the grant edge survives to earn another service
        w_pend_n = (r_pend & ~w_grant) | ped_req;
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase   <= S_RED;
            r_rem     <= RED_LOAD;
            r_adv     <= 1'b0;
            r_ack     <= 1'b0;
            r_pend    <= 1'b0;
`ifdef TRAFFIC_FLASH_EN
            r_flash_d <= 1'b0;
            r_lamp    <= 1'b0;
`endif
        end else begin
            r_phase   <= w_phase_n;
            r_rem     <= w_rem_n;
            r_adv     <= w_adv_n;
            r_ack     <= w_ack_n;
            r_pend    <= w_pend_n;
`ifdef TRAFFIC_FLASH_EN
            r_flash_d <= flash_mode;
            r_lamp    <= w_lamp_n;
`endif
        end
    end

    assign phase     = r_phase;
    assign remaining = r_rem;
    assign advance   = r_adv;
    assign ped_ack   = r_ack;
    assign tick      = w_tick;
`ifdef TRAFFIC_FLASH_EN
    assign flash_lamp = r_lamp;
`endif

endmodule

// File: doc/traffic_phase_timer.md
Name: traffic_phase_timer

Overview:
- Upstream timing stage for the traffic light sequencer.
- Owns the dwell time of each phase (RED, GREEN, YELLOW) from a prescaled tick.
- Emits a one-cycle advance strobe plus the current phase code; the downstream sequencer steps its lamps on each strobe.
- Handles a pedestrian request: the current GREEN is shortened and the next RED is extended.

Parameters:
- CLK_DIV, 1000: clk cycles per tick; must be >= 1.
- CNT_W, 8: width of the dwell counter and of `remaining`.
- RED_TICKS, 30: RED dwell in ticks; must be >= 1.
- GREEN_TICKS, 25: GREEN dwell in ticks; must be >= 1.
- YELLOW_TICKS, 5: YELLOW dwell in ticks; must be >= 1.
- PED_EXT_TICKS, 10: extra RED ticks granted to a pedestrian request.
- PED_GREEN_MAX, 3: maximum GREEN ticks left once a request is pending; must be >= 1.
- Width constraint: RED_TICKS + PED_EXT_TICKS <= 2^CNT_W.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  run/hold.
- ped_req  input  1  pedestrian request; level sampled every clk.
- ped_ack  output  1  one-cycle pulse when the extended RED is granted.
- phase  output  2  current phase code (RED=0, GREEN=1, YELLOW=2).
- advance  output  1  one-cycle strobe marking a phase change.
- tick  output  1  one-cycle prescaler strobe.
- remaining  output  CNT_W  ticks left in the current phase, minus 1.

Behaviour:
- Reset (async assert, sync release): phase=RED, remaining=RED_TICKS-1, prescaler=0, pend=0, tick=0, advance=0, ped_ack=0.
- All outputs are registered.
- Prescaler:
  - Counts 0..CLK_DIV-1 while enable=1, then wraps to 0.
  - tick=1 for the cycle after the count reaches CLK_DIV-1.
  - With CLK_DIV=1, tick is high every enabled cycle.
- enable=0: prescaler, remaining, phase and pend hold; tick and advance are 0. ped_req is still latched into pend.
- Phase FSM: RED -> GREEN -> YELLOW -> RED. Code 3 is illegal: on the next clk go to RED, load remaining=RED_TICKS-1, advance=1.
- On a tick cycle:
  - remaining>0: remaining decrements.
  - remaining==0: phase moves to the next state on the same edge, advance=1 for that one cycle, and remaining loads the next dwell minus 1.
  - Latency: advance rises one clk after the terminating tick.
- Dwell of 1: the phase lasts exactly one tick.
- Pedestrian pend flag:
  - Set on any clk with ped_req=1.
  - Cleared only on the cycle the extended RED is entered.
  - If set and clear coincide (ped_req=1 on the grant edge), the flag stays 1. This grants a second cycle of service.
- GREEN shortening: while pend=1 and phase=GREEN, remaining is clamped to min(remaining, PED_GREEN_MAX-1) on every clk. The clamp also applies on the GREEN entry edge.
- RED extension:
  - Entering RED with pend=1 loads remaining=RED_TICKS+PED_EXT_TICKS-1 and pulses ped_ack for 1 cycle.
  - A request during RED or YELLOW does not alter the current phase; it is served at the next GREEN/RED.
- Reset mid-phase: everything returns to the reset values immediately and any pending request is lost.

Optional Feature:
- Macro: TRAFFIC_FLASH_EN.
- When defined:
  - Adds input flash_mode (1) and output flash_lamp (1).
  - flash_mode=1: phase is forced to YELLOW, advance=0, flash_lamp toggles on every tick, and ped requests still latch.
  - flash_mode falling: flash_lamp=0, phase=RED, remaining=RED_TICKS-1 (extended if pend=1), advance=1 for 1 cycle.
- When undefined: neither port exists and behaviour is exactly as above.

Decomposition:
- Shared package traffic_pkg holds:
  - phase_t enum {RED=0, GREEN=1, YELLOW=2}, 2 bits.
  - Lamp constants LAMP_RED=3'b100, LAMP_YELLOW=3'b010, LAMP_GREEN=3'b001.
  - The helper function next_phase(phase_t).
- The downstream sequencer and this block share the package.
- One sub-module: tick_prescaler (params CLK_DIV, enable in, tick out).

Test Plan:
All scenarios use CLK_DIV=4, CNT_W=4, RED=3, GREEN=2, YELLOW=1, PED_EXT=2, PED_GREEN_MAX=1.
1. Reset, then enable=1 for 40 clk -> tick every 4th clk; advance on ticks 3, 5, 6, 9; phase sequence 0, 1, 2, 0; remaining reloads 1, 0, 2.
2. ped_req pulsed 1 clk at the start of GREEN (remaining=1) -> remaining clamps to 0; advance to YELLOW at the next tick; at RED entry ped_ack=1 for 1 clk and remaining=4; RED lasts 5 ticks.
3. ped_req held high across the RED grant edge -> ped_ack pulses once, pend remains 1, and the following GREEN is also shortened.
4. enable=0 for 10 clk mid-GREEN -> tick=0, advance=0, phase and remaining frozen; sequence resumes with identical timing after enable=1.
5. reset_n asserted mid-YELLOW with pend=1 -> outputs go to reset values asynchronously, the next RED is unextended, and ped_ack is never pulsed.
6. TRAFFIC_FLASH_EN: flash_mode=1 for 8 ticks -> phase=2 throughout, flash_lamp toggles 8 times, advance=0; on release phase=0, advance=1, remaining=2.
